pipelined_adder: RTL and testbench

- Parametrised N-bit add/subtract unit, pipelined into STAGES chunk stages of N/STAGES bits each, with carry rippling stage to stage.
- Valid/ready handshake on input and output; full throughput of one operation per cycle; backpressure stalls the whole pipe.
- Adds signed-overflow and zero flags.
- Drop-in arithmetic datapath for wide operands where a single-cycle ripple adder misses timing.

---
 rtl/pipelined_adder.sv | 113 +++++++++++
 tb/tb_pipelined_adder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined N-bit add/subtract unit. STAGES chunk stages ripple the carry one stage at a time.
// Flow control is valid/ready, and ready is resolved back-to-front within a single cycle.
module pipelined_adder #(
  parameter int N      = 16,
  parameter int STAGES = 4   // N must be a multiple of STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         Ovf,
  output logic         Zero
);
  localparam int CHUNK = N / STAGES;

  // src_*[k] is what stage k consumes: the input beat for k=0, otherwise stage k-1's registers.
  // Operands stay right-aligned, so every stage adds bits [CHUNK-1:0].
  // The result shifts in from the top and is aligned once the last chunk lands.
  logic [STAGES-1:0]        src_v, src_c, stg_vld, rdy;
  logic [STAGES-1:0][N-1:0] src_a, src_b, src_r;

  assign src_v[0] = in_valid;
  assign src_a[0] = A;
  assign src_b[0] = op ? ~B : B;
  assign src_c[0] = op ? ~Cin : Cin;
  assign src_r[0] = '0;

  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !stg_vld[STAGES-1] || out_ready;
    for (int k = STAGES-2; k >= 0; k--) rdy[k] = !stg_vld[k] || rdy[k+1];
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [CHUNK:0] csum;
    logic [N-1:0]   r_d;

    assign csum = {1'b0, src_a[k][CHUNK-1:0]} + {1'b0, src_b[k][CHUNK-1:0]}
                + {{CHUNK{1'b0}}, src_c[k]};
    assign r_d  = N'({csum[CHUNK-1:0], src_r[k]} >> CHUNK);

    if (k < STAGES-1) begin : g_mid
      logic         vld_q, c_q;
      logic [N-1:0] a_q, b_q, r_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= 1'b0;
          c_q   <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          r_q   <= '0;
        end else if (rdy[k]) begin
          vld_q <= src_v[k];
          if (src_v[k]) begin
            c_q <= csum[CHUNK];
            a_q <= src_a[k] >> CHUNK;
            b_q <= src_b[k] >> CHUNK;
            r_q <= r_d;
          end
        end
      end

      assign stg_vld[k]  = vld_q;
      assign src_v[k+1]  = vld_q;
      assign src_c[k+1]  = c_q;
      assign src_a[k+1]  = a_q;
      assign src_b[k+1]  = b_q;
      assign src_r[k+1]  = r_q;
    end else begin : g_last
      logic         vld_q, c_q, ovf_q, zero_q, cmsb;
      logic [N-1:0] r_q;

      // The carry into the MSB is recovered from the MSB sum bit and its two operand bits.
      assign cmsb = src_a[k][CHUNK-1] ^ src_b[k][CHUNK-1] ^ csum[CHUNK-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= 1'b0;
          c_q    <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
          r_q    <= '0;
        end else if (rdy[k]) begin
          vld_q <= src_v[k];
          if (src_v[k]) begin
            c_q    <= csum[CHUNK];
            ovf_q  <= cmsb ^ csum[CHUNK];
            zero_q <= (r_d == '0);
            r_q    <= r_d;
          end
        end
      end

      assign stg_vld[k] = vld_q;
      assign out_valid  = vld_q;
      assign Sum        = r_q;
      assign Cout       = c_q;
      assign Ovf        = ovf_q;
      assign Zero       = zero_q;
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder in three configurations (16/4, 16/1, 8/2).
// Every result is compared against a plain-arithmetic model of add/subtract.
module tb_pipelined_adder;
  localparam int ND = 3;
  typedef struct packed { logic [15:0] sum; logic co; logic ovf; logic zr; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ND-1:0]       iv = '0, ordy = '1, cin = '0, op = '0;
  logic [ND-1:0][15:0] a = '0, b = '0;
  logic ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2, ovf0, ovf1, ovf2, zr0, zr1, zr2;
  logic [15:0] s0, s1;
  logic [7:0]  s2;
  logic [ND-1:0] ir, ov, acc, got;

  int errors = 0, checks = 0, cyc = 0;
  int lat [ND] = '{4, 1, 2};
  res_t e0[$], e1[$], e2[$], o0[$], o1[$], o2[$];
  int acyc0[$], ocyc0[$];

  assign ir = {ir2, ir1, ir0};
  assign ov = {ov2, ov1, ov0};

  always #5 clk = ~clk;

  pipelined_adder #(.N(16), .STAGES(4)) u_d0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
    .A(a[0]), .B(b[0]), .Cin(cin[0]), .op(op[0]), .out_valid(ov0), .out_ready(ordy[0]),
    .Sum(s0), .Cout(co0), .Ovf(ovf0), .Zero(zr0));
  pipelined_adder #(.N(16), .STAGES(1)) u_d1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
    .A(a[1]), .B(b[1]), .Cin(cin[1]), .op(op[1]), .out_valid(ov1), .out_ready(ordy[1]),
    .Sum(s1), .Cout(co1), .Ovf(ovf1), .Zero(zr1));
  pipelined_adder #(.N(8), .STAGES(2)) u_d2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2),
    .A(a[2][7:0]), .B(b[2][7:0]), .Cin(cin[2]), .op(op[2]), .out_valid(ov2), .out_ready(ordy[2]),
    .Sum(s2), .Cout(co2), .Ovf(ovf2), .Zero(zr2));

  // Reference: integer arithmetic on the operand values, with signed range checks for overflow.
  function automatic res_t model(input int n, input logic [15:0] av, bv, input logic c, o);
    int m, ua, ub, sa, sb, r, s;
    res_t q;
    m  = 1 << n;
    ua = int'(av) & (m-1);
    ub = int'(bv) & (m-1);
    sa = (ua >= m/2) ? ua - m : ua;
    sb = (ub >= m/2) ? ub - m : ub;
    if (!o) begin
      r = ua + ub + int'(c); s = sa + sb + int'(c); q.co = (r >= m);
    end else begin
      r = ua - ub - int'(c); s = sa - sb - int'(c); q.co = (r >= 0);
    end
    q.sum = 16'(r & (m-1));
    q.ovf = (s >= m/2) || (s < -(m/2));
    q.zr  = ((r & (m-1)) == 0);
    return q;
  endfunction

  function automatic res_t mk(input logic [15:0] s, input logic c, v, z);
    return {s, c, v, z};
  endfunction

  // Called at a falling edge: samples handshakes 1ns later, then advances to the next falling edge.
  task automatic tick();
    #1;
    acc = iv & ir;
    got = ov & ordy;
    if (acc[0]) begin e0.push_back(model(16, a[0], b[0], cin[0], op[0])); acyc0.push_back(cyc); end
    if (acc[1]) e1.push_back(model(16, a[1], b[1], cin[1], op[1]));
    if (acc[2]) e2.push_back(model(8, a[2], b[2], cin[2], op[2]));
    if (got[0]) begin o0.push_back({s0, co0, ovf0, zr0}); ocyc0.push_back(cyc); end
    if (got[1]) o1.push_back({s1, co1, ovf1, zr1});
    if (got[2]) o2.push_back({8'h00, s2, co2, ovf2, zr2});
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear();
    e0.delete(); e1.delete(); e2.delete(); o0.delete(); o1.delete(); o2.delete();
    acyc0.delete(); ocyc0.delete();
  endtask

  task automatic send0(input logic [15:0] av, bv, input logic c, o);
    bit done = 0;
    a[0] = av; b[0] = bv; cin[0] = c; op[0] = o; iv[0] = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      tick();
      done = acc[0];
    end
    iv[0] = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout beat %h/%h never accepted", av, bv);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (ov !== 3'b000) begin errors++; $display("FAIL reset_out_valid got=%b exp=000", ov); end
    checks++; if ({co2, co1, co0, ovf2, ovf1, ovf0, zr2, zr1, zr0} !== 9'h0) begin
      errors++; $display("FAIL reset_flags got=%b exp=0", {co2, co1, co0, ovf2, ovf1, ovf0, zr2, zr1, zr0});
    end
    checks++; if ({s0, s1, s2} !== 40'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0", {s0, s1, s2}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (ir !== 3'b111) begin errors++; $display("FAIL reset_in_ready got=%b exp=111", ir); end
    @(negedge clk);
  endtask

  task automatic test_add_stream();
    res_t ex [3];
    ex[0] = mk(16'h0000, 0, 0, 1); ex[1] = mk(16'h0008, 0, 0, 0); ex[2] = mk(16'h0000, 1, 0, 1);
    clear(); ordy[0] = 1'b1;
    send0(16'h0000, 16'h0000, 0, 0);
    send0(16'h0005, 16'h0003, 0, 0);
    send0(16'hFFFF, 16'h0001, 0, 0);
    repeat (8) tick();
    checks++; if (o0.size() != 3) begin errors++; $display("FAIL add_count got=%0d exp=3", o0.size()); end
    for (int k = 0; k < 3 && k < o0.size(); k++) begin
      checks++; if (o0[k] !== ex[k]) begin errors++; $display("FAIL add_result[%0d] got=%h exp=%h", k, o0[k], ex[k]); end
      checks++; if (ocyc0[k] - acyc0[0] != 4 + k) begin
        errors++; $display("FAIL add_latency[%0d] got=%0d exp=%0d", k, ocyc0[k] - acyc0[0], 4 + k);
      end
    end
  endtask

  task automatic test_subtract();
    res_t ex [2];
    ex[0] = mk(16'h000F, 1, 0, 0); ex[1] = mk(16'hFFFF, 0, 0, 0);
    clear();
    send0(16'h0010, 16'h0001, 0, 1);
    send0(16'h0000, 16'h0001, 0, 1);
    repeat (8) tick();
    checks++; if (o0.size() != 2) begin errors++; $display("FAIL sub_count got=%0d exp=2", o0.size()); end
    for (int k = 0; k < 2 && k < o0.size(); k++) begin
      checks++; if (o0[k] !== ex[k]) begin errors++; $display("FAIL sub_result[%0d] got=%h exp=%h", k, o0[k], ex[k]); end
    end
  endtask

  task automatic test_overflow();
    res_t ex [2];
    ex[0] = mk(16'h8000, 0, 1, 0); ex[1] = mk(16'h7FFF, 1, 1, 0);
    clear();
    send0(16'h7FFF, 16'h0001, 0, 0);
    send0(16'h8000, 16'h0001, 0, 1);
    repeat (8) tick();
    checks++; if (o0.size() != 2) begin errors++; $display("FAIL ovf_count got=%0d exp=2", o0.size()); end
    for (int k = 0; k < 2 && k < o0.size(); k++) begin
      checks++; if (o0[k] !== ex[k]) begin errors++; $display("FAIL ovf_result[%0d] got=%h exp=%h", k, o0[k], ex[k]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] av [6], bv [6];
    logic [5:0]  cv, opv;
    res_t snap;
    int n = 0;
    for (int k = 0; k < 6; k++) begin av[k] = 16'($urandom); bv[k] = 16'($urandom); end
    cv = 6'($urandom); opv = 6'($urandom);
    clear(); ordy[0] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      a[0] = av[n]; b[0] = bv[n]; cin[0] = cv[n]; op[0] = opv[n]; iv[0] = 1'b1;
      tick();
      if (acc[0]) n++;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_accepted got=%0d exp=4", n); end
    checks++; if (ir0 !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", ir0); end
    snap = {s0, co0, ovf0, zr0};
    checks++; if (e0.size() == 0 || snap !== e0[0] || ov0 !== 1'b1) begin
      errors++; $display("FAIL bp_head got=%h valid=%b exp_first_result_valid", snap, ov0);
    end
    repeat (3) tick();
    checks++; if ({s0, co0, ovf0, zr0} !== snap || ov0 !== 1'b1 || n != 4) begin
      errors++; $display("FAIL bp_hold got=%h exp=%h", {s0, co0, ovf0, zr0}, snap);
    end
    ordy[0] = 1'b1;
    for (int t = 0; t < 50 && n < 6; t++) begin
      a[0] = av[n]; b[0] = bv[n]; cin[0] = cv[n]; op[0] = opv[n]; iv[0] = 1'b1;
      tick();
      if (acc[0]) n++;
    end
    iv[0] = 1'b0;
    repeat (8) tick();
    checks++; if (o0.size() != 6 || e0.size() != 6) begin
      errors++; $display("FAIL bp_count got=%0d exp=6", o0.size());
    end
    for (int k = 0; k < o0.size() && k < e0.size(); k++) begin
      checks++; if (o0[k] !== e0[k]) begin errors++; $display("FAIL bp_result[%0d] got=%h exp=%h", k, o0[k], e0[k]); end
    end
  endtask

  task automatic test_reset_midflight();
    clear(); ordy[0] = 1'b1;
    send0(16'h1111, 16'h2222, 0, 0);
    send0(16'h0303, 16'h0404, 1, 0);
    send0(16'h5555, 16'h0101, 0, 1);
    #2 rst = 1'b1;
    #1;
    checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", ov0); end
    checks++; if ({s0, co0, ovf0, zr0} !== 19'h0) begin
      errors++; $display("FAIL rstmid_outputs got=%h exp=0", {s0, co0, ovf0, zr0});
    end
    @(negedge clk);
    rst = 1'b0;
    clear();
    repeat (6) tick();
    checks++; if (o0.size() != 0) begin errors++; $display("FAIL rstmid_stale got=%0d exp=0", o0.size()); end
    send0(16'h0102, 16'h0201, 0, 0);
    repeat (6) tick();
    checks++; if (o0.size() != 1 || o0[0] !== mk(16'h0303, 0, 0, 0)) begin
      errors++; $display("FAIL rstmid_new got_count=%0d exp=1 result 0303", o0.size());
    end
  endtask

  task automatic test_sweep();
    int sent [ND];
    int t0, t1;
    // Latency on an idle pipe with out_ready held high
    for (int i = 0; i < ND; i++) begin
      clear(); ordy = '1;
      a[i] = 16'h00A5; b[i] = 16'h005A; cin[i] = 1'b1; op[i] = 1'b0; iv[i] = 1'b1;
      t0 = -1; t1 = -1;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (acc[i] && t0 < 0) begin t0 = cyc; iv[i] = 1'b0; end
        if (got[i] && t1 < 0) t1 = cyc;
      end
      checks++; if (t0 < 0 || t1 - t0 != lat[i]) begin
        errors++; $display("FAIL sweep_latency[%0d] got=%0d exp=%0d", i, t1 - t0, lat[i]);
      end
    end
    // Randomized add/sub with random backpressure on all three configurations
    clear();
    for (int i = 0; i < ND; i++) sent[i] = 0;
    for (int c = 0; c < 3000 && (sent[0] < 60 || sent[1] < 60 || sent[2] < 60); c++) begin
      for (int i = 0; i < ND; i++) begin
        if (!iv[i] && sent[i] < 60 && $urandom_range(3) != 0) begin
          a[i] = 16'($urandom); b[i] = 16'($urandom);
          cin[i] = 1'($urandom); op[i] = 1'($urandom); iv[i] = 1'b1;
        end
        ordy[i] = ($urandom_range(3) != 0);
      end
      tick();
      for (int i = 0; i < ND; i++) if (acc[i]) begin sent[i]++; iv[i] = 1'b0; end
    end
    iv = '0; ordy = '1;
    repeat (10) tick();
    checks++; if (o0.size() != e0.size() || sent[0] != 60) begin
      errors++; $display("FAIL sweep_count0 got=%0d exp=%0d", o0.size(), e0.size());
    end
    for (int k = 0; k < o0.size() && k < e0.size(); k++) begin
      checks++; if (o0[k] !== e0[k]) begin errors++; $display("FAIL sweep0[%0d] got=%h exp=%h", k, o0[k], e0[k]); end
    end
    checks++; if (o1.size() != e1.size() || sent[1] != 60) begin
      errors++; $display("FAIL sweep_count1 got=%0d exp=%0d", o1.size(), e1.size());
    end
    for (int k = 0; k < o1.size() && k < e1.size(); k++) begin
      checks++; if (o1[k] !== e1[k]) begin errors++; $display("FAIL sweep1[%0d] got=%h exp=%h", k, o1[k], e1[k]); end
    end
    checks++; if (o2.size() != e2.size() || sent[2] != 60) begin
      errors++; $display("FAIL sweep_count2 got=%0d exp=%0d", o2.size(), e2.size());
    end
    for (int k = 0; k < o2.size() && k < e2.size(); k++) begin
      checks++; if (o2[k] !== e2[k]) begin errors++; $display("FAIL sweep2[%0d] got=%h exp=%h", k, o2[k], e2[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_stream();
    test_subtract();
    test_overflow();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
